// File: rtl/vdma_axi4s_to_axi4_ring_core.sv
// Video write DMA: AXI4-Stream frames into a ring of BUF_NUM buffers through an AXI4 write master.
// Define VDMA_BRESP_ERR_EN to add ctl_err_count, a saturating count of non-OKAY B responses.
module vdma_axi4s_to_axi4_ring_core #(
  parameter int AXI4_ID_WIDTH     = 6,
  parameter int AXI4_ADDR_WIDTH   = 32,
  parameter int AXI4_DATA_SIZE    = 2,
  parameter int AXI4_DATA_WIDTH   = 8 << AXI4_DATA_SIZE,
  parameter int AXI4_LEN_WIDTH    = 8,
  parameter int BUF_NUM           = 3,
  parameter int BUF_WIDTH         = 2,
  parameter int OUTSTANDING_WIDTH = 4,
  parameter int STRIDE_WIDTH      = 14,
  parameter int H_WIDTH           = 12,
  parameter int V_WIDTH           = 12,
  parameter int INDEX_WIDTH       = 8
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         ctl_enable,
  input  logic                         ctl_update,
  output logic                         ctl_busy,
  output logic [INDEX_WIDTH-1:0]       ctl_index,
  output logic [BUF_WIDTH-1:0]         ctl_buf,
  output logic [BUF_WIDTH-1:0]         ctl_last_buf,
  output logic                         ctl_last_valid,
`ifdef VDMA_BRESP_ERR_EN
  output logic [7:0]                   ctl_err_count,
`endif
  input  logic [AXI4_ADDR_WIDTH-1:0]   param_addr,
  input  logic [AXI4_ADDR_WIDTH-1:0]   param_buf_size,
  input  logic [STRIDE_WIDTH-1:0]      param_stride,
  input  logic [H_WIDTH-1:0]           param_width,
  input  logic [V_WIDTH-1:0]           param_height,
  input  logic [AXI4_LEN_WIDTH-1:0]    param_awlen,
  output logic [AXI4_ID_WIDTH-1:0]     m_axi4_awid,
  output logic [AXI4_ADDR_WIDTH-1:0]   m_axi4_awaddr,
  output logic [1:0]                   m_axi4_awburst,
  output logic [3:0]                   m_axi4_awcache,
  output logic [AXI4_LEN_WIDTH-1:0]    m_axi4_awlen,
  output logic                         m_axi4_awlock,
  output logic [2:0]                   m_axi4_awprot,
  output logic [3:0]                   m_axi4_awqos,
  output logic [3:0]                   m_axi4_awregion,
  output logic [2:0]                   m_axi4_awsize,
  output logic                         m_axi4_awvalid,
  input  logic                         m_axi4_awready,
  output logic [AXI4_DATA_WIDTH/8-1:0] m_axi4_wstrb,
  output logic [AXI4_DATA_WIDTH-1:0]   m_axi4_wdata,
  output logic                         m_axi4_wlast,
  output logic                         m_axi4_wvalid,
  input  logic                         m_axi4_wready,
  input  logic [AXI4_ID_WIDTH-1:0]     m_axi4_bid,
  input  logic [1:0]                   m_axi4_bresp,
  input  logic                         m_axi4_bvalid,
  output logic                         m_axi4_bready,
  input  logic                         s_axi4s_tuser,
  input  logic                         s_axi4s_tlast,
  input  logic [AXI4_DATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic                         s_axi4s_tvalid,
  output logic                         s_axi4s_tready
);

  localparam int CW = (H_WIDTH > AXI4_LEN_WIDTH) ? H_WIDTH : AXI4_LEN_WIDTH;

  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_AW, ST_W, ST_DRAIN} state_t;

  state_t                       r_state, w_next;
  logic                         r_loaded;
  logic [AXI4_ADDR_WIDTH-1:0]   r_sh_addr, r_sh_buf_size;
  logic [STRIDE_WIDTH-1:0]      r_sh_stride;
  logic [H_WIDTH-1:0]           r_sh_width, r_x;
  logic [V_WIDTH-1:0]           r_sh_height, r_y;
  logic [AXI4_LEN_WIDTH-1:0]    r_sh_awlen, r_len, r_beat;
  logic [AXI4_ADDR_WIDTH-1:0]   r_line_addr, r_addr;
  logic [OUTSTANDING_WIDTH-1:0] r_outstanding;
  logic [INDEX_WIDTH-1:0]       r_index;
  logic [BUF_WIDTH-1:0]         r_buf, r_last_buf;
  logic                         r_last_valid;

  // Parameters in force for a frame that starts this cycle (fresh values when updating).
  logic [AXI4_ADDR_WIDTH-1:0]   w_f_addr, w_f_buf_size, w_frame_base, w_next_line, w_burst_bytes;
  logic [H_WIDTH-1:0]           w_f_width, w_rem_m1;
  logic [V_WIDTH-1:0]           w_f_height;
  logic [AXI4_LEN_WIDTH-1:0]    w_len;
  logic w_frame_start, w_frame_empty, w_out_full, w_aw_fire, w_w_fire, w_b_fire;
  logic w_wlast, w_line_end, w_frame_end, w_drain_done, w_unused;

  assign w_frame_start = (r_state == ST_SYNC) && s_axi4s_tvalid && s_axi4s_tuser;
  assign w_f_addr      = ctl_update ? param_addr     : r_sh_addr;
  assign w_f_buf_size  = ctl_update ? param_buf_size : r_sh_buf_size;
  assign w_f_width     = ctl_update ? param_width    : r_sh_width;
  assign w_f_height    = ctl_update ? param_height   : r_sh_height;
  assign w_frame_base  = w_f_addr + AXI4_ADDR_WIDTH'(r_buf) * w_f_buf_size;
  assign w_frame_empty = (w_f_width == '0) || (w_f_height == '0);

  assign w_rem_m1      = r_sh_width - r_x - H_WIDTH'(1);
  assign w_len         = (CW'(w_rem_m1) > CW'(r_sh_awlen)) ? r_sh_awlen : AXI4_LEN_WIDTH'(w_rem_m1);
  assign w_burst_bytes = (AXI4_ADDR_WIDTH'(r_len) + AXI4_ADDR_WIDTH'(1)) << AXI4_DATA_SIZE;
  assign w_next_line   = r_line_addr + AXI4_ADDR_WIDTH'(r_sh_stride);

  assign w_out_full    = &r_outstanding;
  assign w_aw_fire     = m_axi4_awvalid && m_axi4_awready;
  assign w_w_fire      = m_axi4_wvalid && m_axi4_wready;
  assign w_b_fire      = m_axi4_bvalid && m_axi4_bready;
  assign w_wlast       = (r_beat == r_len);
  assign w_line_end    = (r_x == r_sh_width - H_WIDTH'(1));
  assign w_frame_end   = w_line_end && (r_y == r_sh_height - V_WIDTH'(1));
  assign w_drain_done  = (r_state == ST_DRAIN) && (r_outstanding == '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_next         = r_state;
    m_axi4_awvalid = 1'b0;
    m_axi4_wvalid  = 1'b0;
    m_axi4_wlast   = 1'b0;
    s_axi4s_tready = 1'b0;
    case (r_state)
      ST_IDLE: if (ctl_enable) w_next = ST_SYNC;
      ST_SYNC: begin
        // The start-of-frame beat is left on the bus so it becomes the first written pixel.
        s_axi4s_tready = ~s_axi4s_tuser;
        if (w_frame_start) w_next = w_frame_empty ? ST_DRAIN : ST_AW;
      end
      ST_AW: begin
        m_axi4_awvalid = ~w_out_full;
        if (w_aw_fire) w_next = ST_W;
      end
      ST_W: begin
        m_axi4_wvalid  = s_axi4s_tvalid;
        m_axi4_wlast   = w_wlast;
        s_axi4s_tready = m_axi4_wready;
        if (w_w_fire && w_wlast) w_next = w_frame_end ? ST_DRAIN : ST_AW;
      end
      ST_DRAIN: if (r_outstanding == '0) w_next = ctl_enable ? ST_SYNC : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_loaded      <= 1'b0;
      r_sh_addr     <= '0;
      r_sh_buf_size <= '0;
      r_sh_stride   <= '0;
      r_sh_width    <= '0;
      r_sh_height   <= '0;
      r_sh_awlen    <= '0;
      r_line_addr   <= '0;
      r_addr        <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_index       <= '0;
      r_buf         <= '0;
      r_last_buf    <= '0;
      r_last_valid  <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE && ctl_enable && !r_loaded) || (w_frame_start && ctl_update)) begin
        r_loaded      <= 1'b1;
        r_sh_addr     <= param_addr;
        r_sh_buf_size <= param_buf_size;
        r_sh_stride   <= param_stride;
        r_sh_width    <= param_width;
        r_sh_height   <= param_height;
        r_sh_awlen    <= param_awlen;
      end
      if (w_frame_start) begin
        r_x         <= '0;
        r_y         <= '0;
        r_beat      <= '0;
        r_line_addr <= w_frame_base;
        r_addr      <= w_frame_base;
      end
      if (w_aw_fire) begin
        r_len  <= w_len;
        r_beat <= '0;
      end
      if (w_w_fire) begin
        r_beat <= r_beat + AXI4_LEN_WIDTH'(1);
        r_x    <= r_x + H_WIDTH'(1);
        if (w_wlast) r_addr <= r_addr + w_burst_bytes;
        if (w_line_end) begin
          r_x         <= '0;
          r_y         <= r_y + V_WIDTH'(1);
          r_line_addr <= w_next_line;
          r_addr      <= w_next_line;
        end
      end
      if (w_drain_done) begin
        r_last_buf   <= r_buf;
        r_last_valid <= 1'b1;
        r_index      <= r_index + INDEX_WIDTH'(1);
        r_buf        <= (r_buf == BUF_WIDTH'(BUF_NUM - 1)) ? '0 : r_buf + BUF_WIDTH'(1);
      end
    end
  end

  // Bursts in flight; a simultaneous issue and retire cancel out.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_outstanding <= '0;
    else if (w_aw_fire && !w_b_fire) r_outstanding <= r_outstanding + OUTSTANDING_WIDTH'(1);
    else if (!w_aw_fire && w_b_fire && r_outstanding != '0)
      r_outstanding <= r_outstanding - OUTSTANDING_WIDTH'(1);
  end

`ifdef VDMA_BRESP_ERR_EN
  logic [7:0] r_err_count;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_err_count <= '0;
    else if (w_b_fire && m_axi4_bresp != 2'b00 && r_err_count != 8'hff)
      r_err_count <= r_err_count + 8'd1;
  end
  assign ctl_err_count = r_err_count;
  assign w_unused      = ^{m_axi4_bid, s_axi4s_tlast};
`else
  assign w_unused      = ^{m_axi4_bid, s_axi4s_tlast, m_axi4_bresp};
`endif

  assign ctl_busy        = (r_state inside {ST_AW, ST_W, ST_DRAIN}) || (r_outstanding != '0);
  assign ctl_index       = r_index;
  assign ctl_buf         = r_buf;
  assign ctl_last_buf    = r_last_buf;
  assign ctl_last_valid  = r_last_valid;
  assign m_axi4_awid     = '0;
  assign m_axi4_awaddr   = r_addr;
  assign m_axi4_awburst  = 2'b01;
  assign m_axi4_awcache  = 4'b0011;
  assign m_axi4_awlen    = w_len;
  assign m_axi4_awlock   = 1'b0;
  assign m_axi4_awprot   = 3'b000;
  assign m_axi4_awqos    = 4'h0;
  assign m_axi4_awregion = 4'h0;
  assign m_axi4_awsize   = 3'(AXI4_DATA_SIZE);
  assign m_axi4_wstrb    = '1;
  assign m_axi4_wdata    = s_axi4s_tdata;
  assign m_axi4_bready   = 1'b1;

endmodule

// File: tb/tb_vdma_axi4s_to_axi4_ring_core.sv
// Bench for vdma_axi4s_to_axi4_ring_core: random-gap stream source, random-ready AXI slave,
// and a frame-level address/data model built from base, buffer ring, stride and burst limits.
module tb_vdma_axi4s_to_axi4_ring_core;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;

  logic        aclk, areset, ctl_enable, ctl_update;
  logic        ctl_busy, ctl_last_valid;
  logic [7:0]  ctl_index;
  logic [1:0]  ctl_buf, ctl_last_buf;
`ifdef VDMA_BRESP_ERR_EN
  logic [7:0]  ctl_err_count;
`endif
  logic [31:0] param_addr, param_buf_size;
  logic [13:0] param_stride;
  logic [11:0] param_width, param_height;
  logic [7:0]  param_awlen;
  logic [5:0]  m_axi4_awid, m_axi4_bid;
  logic [31:0] m_axi4_awaddr, m_axi4_wdata, s_axi4s_tdata;
  logic [1:0]  m_axi4_awburst, m_axi4_bresp;
  logic [3:0]  m_axi4_awcache, m_axi4_awqos, m_axi4_awregion, m_axi4_wstrb;
  logic [7:0]  m_axi4_awlen;
  logic [2:0]  m_axi4_awprot, m_axi4_awsize;
  logic m_axi4_awlock, m_axi4_awvalid, m_axi4_awready, m_axi4_wlast, m_axi4_wvalid, m_axi4_wready;
  logic m_axi4_bvalid, m_axi4_bready, s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tvalid, s_axi4s_tready;

  int vectors = 0;
  int errors  = 0;

  aw_t         aw_got[$], exp_aw[$];
  logic [32:0] w_got[$];
  logic [31:0] sent_q[$];
  int pending_b = 0, bresp_err_left = 0, aw_wait = 0, unstable = 0;
  bit aw_slow = 0, w_toggle = 0, aw_stall = 0, tb_abort = 0, drv_req = 0, drv_timeout = 0;
  logic [31:0] stall_addr;
  logic [7:0]  stall_len;
  int drv_n, drv_junk;

  // Model shadow copy of the frame parameters and ring position.
  logic [31:0] m_addr, m_bs, m_stride;
  int          m_w, m_h, m_awlen, m_buf;
  logic [7:0]  m_index;

  vdma_axi4s_to_axi4_ring_core dut (
    .aclk(aclk), .areset(areset), .ctl_enable(ctl_enable), .ctl_update(ctl_update),
    .ctl_busy(ctl_busy), .ctl_index(ctl_index), .ctl_buf(ctl_buf),
    .ctl_last_buf(ctl_last_buf), .ctl_last_valid(ctl_last_valid),
`ifdef VDMA_BRESP_ERR_EN
    .ctl_err_count(ctl_err_count),
`endif
    .param_addr(param_addr), .param_buf_size(param_buf_size), .param_stride(param_stride),
    .param_width(param_width), .param_height(param_height), .param_awlen(param_awlen),
    .m_axi4_awid(m_axi4_awid), .m_axi4_awaddr(m_axi4_awaddr), .m_axi4_awburst(m_axi4_awburst),
    .m_axi4_awcache(m_axi4_awcache), .m_axi4_awlen(m_axi4_awlen), .m_axi4_awlock(m_axi4_awlock),
    .m_axi4_awprot(m_axi4_awprot), .m_axi4_awqos(m_axi4_awqos), .m_axi4_awregion(m_axi4_awregion),
    .m_axi4_awsize(m_axi4_awsize), .m_axi4_awvalid(m_axi4_awvalid), .m_axi4_awready(m_axi4_awready),
    .m_axi4_wstrb(m_axi4_wstrb), .m_axi4_wdata(m_axi4_wdata), .m_axi4_wlast(m_axi4_wlast),
    .m_axi4_wvalid(m_axi4_wvalid), .m_axi4_wready(m_axi4_wready),
    .m_axi4_bid(m_axi4_bid), .m_axi4_bresp(m_axi4_bresp), .m_axi4_bvalid(m_axi4_bvalid),
    .m_axi4_bready(m_axi4_bready),
    .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast), .s_axi4s_tdata(s_axi4s_tdata),
    .s_axi4s_tvalid(s_axi4s_tvalid), .s_axi4s_tready(s_axi4s_tready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI slave: drives readies/B at negedge, records handshakes 2 ns later.
  initial begin
    m_axi4_awready = 1'b0; m_axi4_wready = 1'b0; m_axi4_bvalid = 1'b0;
    m_axi4_bresp = 2'b00; m_axi4_bid = '0;
    forever begin
      @(negedge aclk);
      m_axi4_awready = aw_slow ? (aw_wait >= 5) : ($urandom_range(0, 3) != 0);
      m_axi4_wready  = w_toggle ? ~m_axi4_wready : ($urandom_range(0, 4) != 0);
      if (pending_b > 0 && !areset && $urandom_range(0, 2) != 0) begin
        m_axi4_bvalid = 1'b1;
        m_axi4_bresp  = (bresp_err_left > 0) ? 2'b10 : 2'b00;
        if (bresp_err_left > 0) bresp_err_left--;
        pending_b--;
      end else begin
        m_axi4_bvalid = 1'b0;
        m_axi4_bresp  = 2'b00;
      end
      #2;
      if (m_axi4_awvalid) begin
        if (aw_stall && (m_axi4_awaddr !== stall_addr || m_axi4_awlen !== stall_len)) unstable++;
        if (m_axi4_awready) begin
          aw_got.push_back('{addr: m_axi4_awaddr, len: m_axi4_awlen});
          aw_wait  = 0;
          aw_stall = 1'b0;
        end else begin
          aw_wait++;
          aw_stall   = 1'b1;
          stall_addr = m_axi4_awaddr;
          stall_len  = m_axi4_awlen;
        end
      end else aw_stall = 1'b0;
      if (m_axi4_wvalid && m_axi4_wready) begin
        w_got.push_back({m_axi4_wlast, m_axi4_wdata});
        if (m_axi4_wlast) pending_b++;
      end
    end
  end

  task automatic drive_beat(input logic [31:0] d, input logic u);
    int budget = 0;
    repeat ($urandom_range(0, 1)) begin @(negedge aclk); s_axi4s_tvalid = 1'b0; end
    forever begin
      @(negedge aclk);
      s_axi4s_tvalid = 1'b1; s_axi4s_tdata = d; s_axi4s_tuser = u;
      #1;
      if (tb_abort) break;
      if (s_axi4s_tready) begin @(posedge aclk); break; end
      budget++;
      if (budget > 5000) begin drv_timeout = 1'b1; break; end
    end
  endtask

  // Stream source: drv_junk discarded beats, then one frame of drv_n random pixels.
  initial begin
    s_axi4s_tvalid = 1'b0; s_axi4s_tuser = 1'b0; s_axi4s_tlast = 1'b0; s_axi4s_tdata = '0;
    forever begin
      logic [31:0] d;
      wait (drv_req);
      for (int j = 0; j < drv_junk && !tb_abort; j++) drive_beat($urandom, 1'b0);
      for (int j = 0; j < drv_n && !tb_abort; j++) begin
        d = $urandom;
        sent_q.push_back(d);
        drive_beat(d, j == 0);
      end
      @(negedge aclk);
      s_axi4s_tvalid = 1'b0; s_axi4s_tuser = 1'b0;
      drv_req = 1'b0;
    end
  end

  task automatic set_params(input logic [31:0] a, input logic [31:0] bs, input logic [13:0] st,
                            input int w, input int h, input int al);
    param_addr = a; param_buf_size = bs; param_stride = st;
    param_width = 12'(w); param_height = 12'(h); param_awlen = 8'(al);
  endtask

  task automatic model_load();
    m_addr = param_addr; m_bs = param_buf_size; m_stride = 32'(param_stride);
    m_w = int'(param_width); m_h = int'(param_height); m_awlen = int'(param_awlen);
  endtask

  task automatic wait_frame();
    int n = 0;
    while ((ctl_index !== m_index + 8'd1 || drv_req) && n < 20000) begin @(negedge aclk); n++; end
    check("frame_done", 64'(n < 20000), 64'd1);
  endtask

  task automatic check_ring();
    check("index",      ctl_index,      m_index + 8'd1);
    check("last_buf",   ctl_last_buf,   m_buf);
    check("last_valid", ctl_last_valid, 1);
    check("buf",        ctl_buf,        (m_buf + 1) % 3);
    m_index = m_index + 8'd1;
    m_buf   = (m_buf + 1) % 3;
  endtask

  task automatic run_frame(input bit upd, input int junk, input bit drop_en);
    logic [31:0] line;
    int x, len, idx, n;
    ctl_update = upd;
    if (upd) model_load();
    exp_aw.delete(); aw_got.delete(); w_got.delete(); sent_q.delete();
    for (int y = 0; y < m_h; y++) begin
      line = m_addr + m_bs * 32'(m_buf) + m_stride * 32'(y);
      x = 0;
      while (x < m_w) begin
        len = (m_w - x - 1 < m_awlen) ? (m_w - x - 1) : m_awlen;
        exp_aw.push_back('{addr: line + 32'(x * 4), len: 8'(len)});
        x += len + 1;
      end
    end
    drv_n = m_w * m_h; drv_junk = junk; drv_timeout = 1'b0; drv_req = 1'b1;
    if (drop_en) begin
      n = 0;
      while (aw_got.size() == 0 && n < 5000) begin @(negedge aclk); n++; end
      ctl_enable = 1'b0;
    end
    wait_frame();
    ctl_update = 1'b0;
    check_ring();
    check("drv_timeout", drv_timeout, 0);
    check("aw_count", aw_got.size(), exp_aw.size());
    for (int i = 0; i < exp_aw.size() && i < aw_got.size(); i++) begin
      check($sformatf("aw_addr[%0d]", i), aw_got[i].addr, exp_aw[i].addr);
      check($sformatf("aw_len[%0d]", i),  aw_got[i].len,  exp_aw[i].len);
    end
    check("w_count", w_got.size(), m_w * m_h);
    idx = 0;
    foreach (exp_aw[i]) begin
      for (int k = 0; k <= int'(exp_aw[i].len); k++) begin
        if (idx < w_got.size() && idx < sent_q.size())
          check($sformatf("w_beat[%0d]", idx), w_got[idx], {k == int'(exp_aw[i].len), sent_q[idx]});
        idx++;
      end
    end
    if (drop_en) begin
      repeat (2) @(negedge aclk);
      check("drop_busy",   ctl_busy,       0);
      check("drop_tready", s_axi4s_tready, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awvalid"},    m_axi4_awvalid, 0);
    check({tag, "_wvalid"},     m_axi4_wvalid,  0);
    check({tag, "_bready"},     m_axi4_bready,  1);
    check({tag, "_tready"},     s_axi4s_tready, 0);
    check({tag, "_busy"},       ctl_busy,       0);
    check({tag, "_index"},      ctl_index,      0);
    check({tag, "_buf"},        ctl_buf,        0);
    check({tag, "_last_buf"},   ctl_last_buf,   0);
    check({tag, "_last_valid"}, ctl_last_valid, 0);
`ifdef VDMA_BRESP_ERR_EN
    check({tag, "_err_count"},  ctl_err_count,  0);
`endif
  endtask

  initial begin
    int n;
    areset = 1'b1; ctl_enable = 1'b0; ctl_update = 1'b0;
    m_buf = 0; m_index = 8'd0;
    set_params(32'h1000, 32'h1_0000, 14'h100, 16, 2, 7);
    repeat (3) @(negedge aclk);
    check_reset_outputs("rst");
    check("awburst", m_axi4_awburst, 2'b01);
    check("awsize",  m_axi4_awsize,  3'd2);
    check("awcache", m_axi4_awcache, 4'b0011);
    check("awprot",  m_axi4_awprot,  3'b000);
    check("awmisc",  {m_axi4_awid, m_axi4_awlock, m_axi4_awqos, m_axi4_awregion}, 0);
    check("wstrb",   m_axi4_wstrb,   4'hf);
    areset = 1'b0;
    @(negedge aclk);

    // First enable loads the shadow; three frames walk the buffer ring.
    ctl_enable = 1'b1;
    model_load();
    bresp_err_left = 2;
    run_frame(1'b0, 2, 1'b0);
`ifdef VDMA_BRESP_ERR_EN
    check("err_count", ctl_err_count, 2);
`endif
    run_frame(1'b0, 1, 1'b0);
    run_frame(1'b0, 0, 1'b0);

    // Narrow line split into len=7 and len=1 bursts, back on buffer 0.
    set_params(32'h1000, 32'h1_0000, 14'h100, 10, 3, 7);
    run_frame(1'b1, 1, 1'b0);

    // Randomized geometry; the first one stalls AW 5 cycles and toggles wready.
    for (int k = 0; k < 3; k++) begin
      aw_slow = (k == 0); w_toggle = (k == 0); unstable = 0;
      set_params($urandom & 32'hffff_fffc, $urandom, 14'($urandom),
                 $urandom_range(1, 40), $urandom_range(1, 4), $urandom_range(0, 15));
      run_frame(1'b1, $urandom_range(0, 3), 1'b0);
      check("aw_stable", unstable, 0);
    end
    aw_slow = 1'b0; w_toggle = 1'b0;

    // Enable dropped mid-frame, then a new parameter set without update.
    set_params(32'h0002_0000, 32'h4000, 14'h200, 24, 3, 3);
    run_frame(1'b1, 1, 1'b1);
    set_params(32'h0005_0000, 32'h800, 14'h40, 5, 1, 0);
    ctl_enable = 1'b1;
    run_frame(1'b0, 1, 1'b0);

    // Zero width: a frame start completes at once with no AXI traffic.
    set_params(32'h0007_0000, 32'h100, 14'h40, 0, 4, 3);
    ctl_update = 1'b1;
    aw_got.delete(); w_got.delete();
    @(negedge aclk);
    s_axi4s_tvalid = 1'b1; s_axi4s_tuser = 1'b1;
    @(negedge aclk);
    s_axi4s_tvalid = 1'b0; s_axi4s_tuser = 1'b0;
    wait_frame();
    ctl_update = 1'b0;
    model_load();
    check_ring();
    check("zero_aw", aw_got.size(), 0);
    check("zero_w",  w_got.size(),  0);

    // Asynchronous reset in the middle of a burst.
    set_params(32'h3000, 32'h1000, 14'h100, 64, 4, 15);
    ctl_update = 1'b1;
    drv_n = 256; drv_junk = 0; drv_req = 1'b1;
    n = 0;
    do begin @(negedge aclk); #3; n++; end while (m_axi4_wvalid !== 1'b1 && n < 5000);
    check("mid_wvalid_seen", m_axi4_wvalid, 1);
    areset = 1'b1; tb_abort = 1'b1; pending_b = 0;
    #1;
    check_reset_outputs("mid");
    check("mid_awaddr", m_axi4_awaddr, 0);
    n = 0;
    while (drv_req && n < 100) begin @(negedge aclk); n++; end
    ctl_update = 1'b0; ctl_enable = 1'b0;
    @(negedge aclk);
    areset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/vdma_axi4s_to_axi4_ring_core.md
Name: vdma_axi4s_to_axi4_ring_core

Overview:
- Next-generation video write DMA core: frames from an AXI4-Stream video input are written to memory through an AXI4 write master.
- Adds a ring of BUF_NUM frame buffers, with hand-off of the last completed buffer index to a downstream reader (double/triple buffering).
- Adds shadowed parameters, frame-drop on disable, and B-response accounting.
- Sits between the video capture pipeline and the memory interconnect. Register front-ends drive it through plain ports.

Parameters:
- AXI4_ID_WIDTH, 6, AWID width (AWID driven 0).
- AXI4_ADDR_WIDTH, 32, address width.
- AXI4_DATA_SIZE, 2, log2 of bytes per beat.
- AXI4_DATA_WIDTH, 8<<AXI4_DATA_SIZE, W data width; also the stream tdata width.
- AXI4_LEN_WIDTH, 8, AWLEN width.
- BUF_NUM, 3, number of frame buffers (1..2^BUF_WIDTH).
- BUF_WIDTH, 2, buffer index width.
- OUTSTANDING_WIDTH, 4, width of the outstanding-B counter; max 2^OUTSTANDING_WIDTH-1 in flight.
- STRIDE_WIDTH, 14, line stride in bytes.
- H_WIDTH, 12, width in beats.
- V_WIDTH, 12, height in lines.
- INDEX_WIDTH, 8, frame counter width.

Ports:
- aclk  in  1  clock.
- areset  in  1  async active-high reset.
- ctl_enable  in  1  run request.
- ctl_update  in  1  latch param_* into shadow at the next frame start.
- ctl_busy  out  1  frame in progress or B responses pending.
- ctl_index  out  INDEX_WIDTH  completed-frame counter.
- ctl_buf  out  BUF_WIDTH  buffer currently being written.
- ctl_last_buf  out  BUF_WIDTH  last completed buffer.
- ctl_last_valid  out  1  ctl_last_buf is valid.
- param_addr  in  AXI4_ADDR_WIDTH  buffer 0 base address.
- param_buf_size  in  AXI4_ADDR_WIDTH  byte offset between buffers.
- param_stride  in  STRIDE_WIDTH  line pitch in bytes.
- param_width  in  H_WIDTH  beats per line.
- param_height  in  V_WIDTH  lines per frame.
- param_awlen  in  AXI4_LEN_WIDTH  max burst length minus 1.
- m_axi4_aw{id,addr,burst,cache,len,lock,prot,qos,region,size,valid}  out; m_axi4_awready  in  AXI4 AW channel.
- m_axi4_w{strb,data,last,valid}  out; m_axi4_wready  in  AXI4 W channel.
- m_axi4_b{id,resp,valid}  in; m_axi4_bready  out  AXI4 B channel.
- s_axi4s_tuser  in  1  start of frame.
- s_axi4s_tlast  in  1  end of line (ignored for addressing).
- s_axi4s_tdata  in  AXI4_DATA_WIDTH  pixel data.
- s_axi4s_tvalid  in  1  stream valid.
- s_axi4s_tready  out  1  stream ready.

Behaviour:
- Reset (async): state IDLE; awvalid=0, wvalid=0, bready=1, tready=0, busy=0, index=0, buf=0, last_buf=0, last_valid=0, outstanding=0.
- Shadow registers load from param_* on the first IDLE->SYNC transition after reset, and at each frame start while ctl_update=1.
- Constant AW fields: burst=INCR(01), size=AXI4_DATA_SIZE, cache=0011, prot=000, lock/qos/region/id=0.
- FSM IDLE: leave to SYNC when ctl_enable=1.
- FSM SYNC: tready=1, beats with tuser=0 are discarded. When tvalid&tuser=1 is seen, that beat is not consumed: set y=0, line address = base + buf*buf_size, then go to AW.
- FSM AW: len = min(awlen, remaining_in_line-1); awvalid=1 until awready, address and len held stable. AW is blocked while outstanding is at max. On handshake, outstanding+1 and go to W.
- FSM W:
  - wvalid=tvalid, tready=wready, wdata=tdata, wstrb all ones.
  - wlast on beat len; on wlast handshake, go to AW with address += (len+1)<<AXI4_DATA_SIZE.
  - At end of line: y+1, line address += stride.
  - At end of the last line: go to DRAIN.
- FSM DRAIN: wait until outstanding=0. Then last_buf=buf, last_valid=1, index+1, buf = (buf==BUF_NUM-1) ? 0 : buf+1. Next state is SYNC if ctl_enable=1, else IDLE.
- B channel: each bvalid decrements outstanding. A simultaneous AW and B handshake leaves outstanding unchanged.
- ctl_enable dropped mid-frame: the current frame completes normally, then the FSM goes to IDLE.
- Widths: all address arithmetic is modulo 2^AXI4_ADDR_WIDTH. param_width=0 or param_height=0 completes the frame immediately with no AXI traffic.
- tuser=1 arriving mid-frame is written as data; no resync.
- ctl_busy=1 in AW, W, DRAIN, or whenever outstanding!=0.

Optional Feature:
- VDMA_BRESP_ERR_EN defined: adds output ctl_err_count[7:0]. It increments (saturating at 255) on each bvalid with bresp!=00. The frame still completes.
- Undefined: the port is absent and bresp is ignored.

Test Plan:
- Reset, enable, width=16, height=2, awlen=7, base=0x1000, stride=0x100, BUF_NUM=3 -> AW addresses 0x1000, 0x1020, 0x1100, 0x1120, all len=7; index=1, last_buf=0, buf=1.
- Width=10, awlen=7 -> per line, bursts len=7 then len=1; wlast on beats 8 and 10.
- Three frames with buf_size=0x10000 -> base addresses cycle 0x1000, 0x11000, 0x21000, then 0x1000; last_buf sequence 0, 1, 2.
- awready held low for 5 cycles and wready toggled every cycle -> awaddr and awlen stable; no data loss; beat count correct.
- ctl_enable=0 mid-frame -> frame finishes and busy falls after the final bvalid; a param change with ctl_update=0 is not applied at the next enable.
- With VDMA_BRESP_ERR_EN: inject bresp=10 twice -> ctl_err_count=2; areset mid-burst -> all outputs return to reset values immediately.
